regfile: RTL and testbench



---
 rtl/regfile.sv | 39 +++
 tb/tb_regfile.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile.sv
// regfile: 32x32 integer register file, two combinational read ports (rs1/rs2 -> rv1/rv2), one synchronous write port (rd/indata/we), sync active-high rst, x0 reads 0; define REGFILE_BYPASS_EN for write-to-read forwarding
module regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  input  logic [ADDR_W-1:0] rd,
  input  logic [DATA_W-1:0] indata,
  input  logic              we,
  output logic [DATA_W-1:0] rv1,
  output logic [DATA_W-1:0] rv2
);
  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic              fwd1, fwd2;
  always_ff @(posedge clk) begin
    if (rst)
      for (int i = 0; i < 2**ADDR_W; i++) mem[i] <= '0;
    else if (we && rd != '0)
      mem[rd] <= indata;
  end
`ifdef REGFILE_BYPASS_EN
  always_comb begin
    fwd1 = we && !rst && rd != '0 && rs1 == rd;
    fwd2 = we && !rst && rd != '0 && rs2 == rd;
  end
`else
  always_comb begin
    fwd1 = 1'b0;
    fwd2 = 1'b0;
  end
`endif
  always_comb begin
    rv1 = rs1 == '0 ? '0 : fwd1 ? indata : mem[rs1];
    rv2 = rs2 == '0 ? '0 : fwd2 ? indata : mem[rs2];
  end
endmodule

// File: tb/tb_regfile.sv
// tb_regfile: directed self-checking bench for regfile
module tb_regfile;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [4:0]  rs1 = '0, rs2 = '0, rd = '0;
  logic [31:0] indata = '0;
  logic        we = 1'b0;
  logic [31:0] rv1, rv2;
  int checks = 0;
  int failures = 0;
  regfile dut (
    .clk(clk), .rst(rst), .rs1(rs1), .rs2(rs2), .rd(rd),
    .indata(indata), .we(we), .rv1(rv1), .rv2(rv2)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    we = 1'b1;
    rd = a;
    indata = d;
    tick();
    we = 1'b0;
  endtask
  task automatic test_reset;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 32; i++) begin
      rs1 = 5'(i);
      rs2 = 5'(31 - i);
      #1;
      checks++;
      if (rv1 !== 32'h0 || rv2 !== 32'h0) begin
        failures++;
        $display("FAIL reset_clear idx=%0d rv1=%h rv2=%h expected 0", i, rv1, rv2);
      end
    end
    wr(5'd5, 32'hDEADBEEF);
    rs1 = 5'd5;
    #1;
    checks++;
    if (rv1 !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL pre_reset_x5 rv1=%h expected deadbeef", rv1);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rs1 = 5'd5;
    rs2 = 5'd31;
    #1;
    checks++;
    if (rv1 !== 32'h0 || rv2 !== 32'h0) begin
      failures++;
      $display("FAIL reset_x5 rv1=%h rv2=%h expected 0", rv1, rv2);
    end
  endtask
  task automatic test_write;
    wr(5'd1, 32'h12345678);
    wr(5'd31, 32'hA5A5A5A5);
    rs1 = 5'd1;
    rs2 = 5'd31;
    #1;
    checks++;
    if (rv1 !== 32'h12345678 || rv2 !== 32'hA5A5A5A5) begin
      failures++;
      $display("FAIL write_readback rv1=%h rv2=%h expected 12345678 a5a5a5a5", rv1, rv2);
    end
    rs1 = 5'd31;
    rs2 = 5'd31;
    #1;
    checks++;
    if (rv1 !== 32'hA5A5A5A5 || rv2 !== 32'hA5A5A5A5) begin
      failures++;
      $display("FAIL same_index rv1=%h rv2=%h expected a5a5a5a5", rv1, rv2);
    end
  endtask
  task automatic test_x0;
    wr(5'd0, 32'hFFFFFFFF);
    rs1 = 5'd0;
    rs2 = 5'd0;
    #1;
    checks++;
    if (rv1 !== 32'h0 || rv2 !== 32'h0) begin
      failures++;
      $display("FAIL x0_hardwire rv1=%h rv2=%h expected 0", rv1, rv2);
    end
    rs1 = 5'd1;
    #1;
    checks++;
    if (rv1 !== 32'h12345678) begin
      failures++;
      $display("FAIL x0_write_side_effect rv1=%h expected 12345678", rv1);
    end
    we = 1'b1;
    rd = 5'd0;
    indata = 32'hCAFEF00D;
    rs1 = 5'd0;
    #1;
    checks++;
    if (rv1 !== 32'h0) begin
      failures++;
      $display("FAIL x0_no_forward rv1=%h expected 0", rv1);
    end
    we = 1'b0;
  endtask
  task automatic test_we_off;
    wr(5'd7, 32'h11);
    we = 1'b0;
    rd = 5'd7;
    indata = 32'h22;
    rs1 = 5'd7;
    rs2 = 5'd7;
    #1;
    checks++;
    if (rv1 !== 32'h11) begin
      failures++;
      $display("FAIL we_off_before rv1=%h expected 11", rv1);
    end
    tick();
    checks++;
    if (rv1 !== 32'h11 || rv2 !== 32'h11) begin
      failures++;
      $display("FAIL we_off rv1=%h rv2=%h expected 11", rv1, rv2);
    end
  endtask
  task automatic test_same_cycle;
    logic [31:0] exp_pre;
`ifdef REGFILE_BYPASS_EN
    exp_pre = 32'h200;
`else
    exp_pre = 32'h100;
`endif
    wr(5'd3, 32'h100);
    we = 1'b1;
    rd = 5'd3;
    indata = 32'h200;
    rs1 = 5'd3;
    rs2 = 5'd3;
    #1;
    checks++;
    if (rv1 !== exp_pre || rv2 !== exp_pre) begin
      failures++;
      $display("FAIL same_cycle_pre rv1=%h rv2=%h expected %h", rv1, rv2, exp_pre);
    end
    rs2 = 5'd7;
    #1;
    checks++;
    if (rv2 !== 32'h11) begin
      failures++;
      $display("FAIL same_cycle_other_port rv2=%h expected 11", rv2);
    end
    tick();
    we = 1'b0;
    checks++;
    if (rv1 !== 32'h200) begin
      failures++;
      $display("FAIL same_cycle_post rv1=%h expected 200", rv1);
    end
  endtask
  task automatic test_reset_collision;
    wr(5'd9, 32'h77);
    rst = 1'b1;
    we = 1'b1;
    rd = 5'd9;
    indata = 32'h55;
    rs2 = 5'd9;
    #1;
    checks++;
    if (rv2 !== 32'h77) begin
      failures++;
      $display("FAIL collision_pre rv2=%h expected 77", rv2);
    end
    tick();
    rst = 1'b0;
    we = 1'b0;
    #1;
    checks++;
    if (rv2 !== 32'h0) begin
      failures++;
      $display("FAIL collision_post rv2=%h expected 0", rv2);
    end
  endtask
  task automatic test_back_to_back;
    logic [31:0] vals [4] = '{32'h0000_0001, 32'h8000_0000, 32'h5A5A_0F0F, 32'hFFFF_FFFF};
    for (int i = 0; i < 4; i++) wr(5'(10 + i), vals[i]);
    for (int i = 0; i < 4; i++) begin
      rs1 = 5'(10 + i);
      rs2 = 5'(13 - i);
      #1;
      checks++;
      if (rv1 !== vals[i] || rv2 !== vals[3 - i]) begin
        failures++;
        $display("FAIL back_to_back i=%0d rv1=%h rv2=%h expected %h %h", i, rv1, rv2, vals[i], vals[3 - i]);
      end
    end
  endtask
  initial begin
    test_reset();
    test_write();
    test_x0();
    test_we_off();
    test_same_cycle();
    test_reset_collision();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
